// File: rtl/audio_mix_pkg.sv
// Shared types, widths and helpers for the audio mixer.
// Used with and without AUDIO_MIX_DCBLOCK_EN.
package audio_mix_pkg;

    localparam int CH_W   = 8;
    localparam int VOL_W  = 4;
    localparam int ACC_W  = 15;
    localparam int SMP_W  = 16;
    localparam int PROD_W = CH_W + VOL_W;
    localparam int NUM_CH = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CH_A,
        ST_CH_B,
        ST_CH_C,
        ST_TAPE,
        ST_SCALE,
        ST_DCB,
        ST_OUT
    } state_t;

    // Inputs captured on the sample strobe.
    typedef struct packed {
        logic [NUM_CH-1:0][CH_W-1:0]  ch;
        logic [NUM_CH-1:0][VOL_W-1:0] vol;
        logic                         tape;
        logic                         stereo;
    } snap_t;

    function automatic logic signed [SMP_W-1:0] sat16(input logic signed [19:0] x);
        if (x > 20'sd32767)
            return 16'sh7fff;
        else if (x < -20'sd32768)
            return 16'sh8000;
        else
            return $signed(x[SMP_W-1:0]);
    endfunction

endpackage

// File: rtl/audio_dc_block.sv
// One-pole DC-blocking high-pass (pole 1 - 2^-8) for a single channel.
// Output is combinational from din and history; history advances on en.
module audio_dc_block
    import audio_mix_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic signed [SMP_W-1:0] din,
    output logic signed [SMP_W-1:0] dout
);

    logic signed [SMP_W-1:0] s_prev, y_prev;
    logic signed [19:0]      d20, sp20, yp20, yd20, y_full;

    always_comb begin
        d20    = din;
        sp20   = s_prev;
        yp20   = y_prev;
        yd20   = y_prev >>> 8;
        y_full = d20 - sp20 + yp20 - yd20;
        dout   = sat16(y_full);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s_prev <= '0;
            y_prev <= '0;
        end else if (en) begin
            s_prev <= din;
            y_prev <= dout;
        end
    end

endmodule

// File: rtl/audio_mix_sat.sv
// Mixes three PSG channels plus tape bit into saturated signed 16-bit stereo.
// Define AUDIO_MIX_DCBLOCK_EN to add the DC-blocking stage (latency 7 vs 6).
module audio_mix_sat
    import audio_mix_pkg::*;
#(
    parameter int TAPE_LEVEL = 1024
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    ce,
    input  logic [CH_W-1:0]         ch_a,
    input  logic [CH_W-1:0]         ch_b,
    input  logic [CH_W-1:0]         ch_c,
    input  logic [VOL_W-1:0]        vol_a,
    input  logic [VOL_W-1:0]        vol_b,
    input  logic [VOL_W-1:0]        vol_c,
    input  logic                    tape_in,
    input  logic                    stereo,
    output logic signed [SMP_W-1:0] left_out,
    output logic signed [SMP_W-1:0] right_out,
    output logic                    out_valid,
    output logic                    busy,
    output logic                    overrun
);

    state_t             state;
    snap_t              snap;
    logic [ACC_W-1:0]   acc_l, acc_r;
    logic [CH_W-1:0]    mul_ch;
    logic [VOL_W-1:0]   mul_vol;
    logic [PROD_W-1:0]  prod;
    logic signed [18:0] s_l, s_r;
    logic signed [SMP_W-1:0] scaled_l, scaled_r;

    // Single multiplier shared across the channel states.
    always_comb begin
        mul_ch  = '0;
        mul_vol = '0;
        case (state)
            ST_CH_A: begin mul_ch = snap.ch[0]; mul_vol = snap.vol[0]; end
            ST_CH_B: begin mul_ch = snap.ch[1]; mul_vol = snap.vol[1]; end
            ST_CH_C: begin mul_ch = snap.ch[2]; mul_vol = snap.vol[2]; end
            default: ;
        endcase
        prod = PROD_W'(mul_ch) * PROD_W'(mul_vol);
    end

    // Unsigned accumulator mapped onto the signed range: acc*8 - 32768.
    always_comb begin
        s_l      = $signed({1'b0, acc_l, 3'b000}) - 19'sd32768;
        s_r      = $signed({1'b0, acc_r, 3'b000}) - 19'sd32768;
        scaled_l = sat16({s_l[18], s_l});
        scaled_r = sat16({s_r[18], s_r});
    end

`ifdef AUDIO_MIX_DCBLOCK_EN
    logic [1:0][SMP_W-1:0] s_q, dcb_y;

    for (genvar g = 0; g < 2; g++) begin : g_dcb
        audio_dc_block u_dcb (
            .clk   (clk),
            .reset (reset),
            .en    (state == ST_DCB),
            .din   (s_q[g]),
            .dout  (dcb_y[g])
        );
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            snap      <= '0;
            acc_l     <= '0;
            acc_r     <= '0;
            left_out  <= '0;
            right_out <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
`ifdef AUDIO_MIX_DCBLOCK_EN
            s_q       <= '0;
`endif
        end else begin
            out_valid <= 1'b0;
            if (ce && state != ST_IDLE)
                overrun <= 1'b1;
            case (state)
                ST_IDLE: if (ce) begin
                    snap.ch     <= {ch_c, ch_b, ch_a};
                    snap.vol    <= {vol_c, vol_b, vol_a};
                    snap.tape   <= tape_in;
                    snap.stereo <= stereo;
                    acc_l       <= '0;
                    acc_r       <= '0;
                    busy        <= 1'b1;
                    state       <= ST_CH_A;
                end
                ST_CH_A: begin
                    acc_l <= acc_l + ACC_W'(prod);
                    if (!snap.stereo)
                        acc_r <= acc_r + ACC_W'(prod);
                    state <= ST_CH_B;
                end
                ST_CH_B: begin
                    // B sits in the centre in stereo, at half level on each side.
                    if (snap.stereo) begin
                        acc_l <= acc_l + ACC_W'(prod >> 1);
                        acc_r <= acc_r + ACC_W'(prod >> 1);
                    end else begin
                        acc_l <= acc_l + ACC_W'(prod);
                        acc_r <= acc_r + ACC_W'(prod);
                    end
                    state <= ST_CH_C;
                end
                ST_CH_C: begin
                    acc_r <= acc_r + ACC_W'(prod);
                    if (!snap.stereo)
                        acc_l <= acc_l + ACC_W'(prod);
                    state <= ST_TAPE;
                end
                ST_TAPE: begin
                    if (snap.tape) begin
                        acc_l <= acc_l + ACC_W'(TAPE_LEVEL);
                        acc_r <= acc_r + ACC_W'(TAPE_LEVEL);
                    end
                    state <= ST_SCALE;
                end
                ST_SCALE: begin
`ifdef AUDIO_MIX_DCBLOCK_EN
                    s_q   <= {scaled_r, scaled_l};
                    state <= ST_DCB;
`else
                    left_out  <= scaled_l;
                    right_out <= scaled_r;
                    out_valid <= 1'b1;
                    state     <= ST_OUT;
`endif
                end
`ifdef AUDIO_MIX_DCBLOCK_EN
                ST_DCB: begin
                    left_out  <= dcb_y[0];
                    right_out <= dcb_y[1];
                    out_valid <= 1'b1;
                    state     <= ST_OUT;
                end
`endif
                ST_OUT: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_audio_mix_sat.sv
// Scoreboard bench for audio_mix_sat: stimulus pushes expected samples from an
// arithmetic model; a negedge monitor pops and compares on out_valid.
module tb_audio_mix_sat;

    localparam int TAPE_LEVEL = 1024;
`ifdef AUDIO_MIX_DCBLOCK_EN
    localparam int LAT = 7;
`else
    localparam int LAT = 6;
`endif

    logic        clk = 1'b0;
    logic        reset, ce, tape_in, stereo;
    logic [7:0]  ch_a, ch_b, ch_c;
    logic [3:0]  vol_a, vol_b, vol_c;
    logic signed [15:0] left_out, right_out;
    logic        out_valid, busy, overrun;

    audio_mix_sat #(.TAPE_LEVEL(TAPE_LEVEL)) dut (
        .clk       (clk),
        .reset     (reset),
        .ce        (ce),
        .ch_a      (ch_a),
        .ch_b      (ch_b),
        .ch_c      (ch_c),
        .vol_a     (vol_a),
        .vol_b     (vol_b),
        .vol_c     (vol_c),
        .tape_in   (tape_in),
        .stereo    (stereo),
        .left_out  (left_out),
        .right_out (right_out),
        .out_valid (out_valid),
        .busy      (busy),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int l;
        int r;
        int cyc;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   ntests = 0, nfail = 0, nvld = 0;
    int   sp[2], yp[2];

    task automatic chk(input string name, input int act, input int expv);
        ntests++;
        if (act != expv) begin
            nfail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic int clamp16(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic int floor256(input int v);
        if (v >= 0) return v / 256;
        return -((-v + 255) / 256);
    endfunction

    // Reference: mix sums, map to signed range, clamp, optional high-pass.
    task automatic push_expected();
        int pa, pb, pc, l, r;
        int s[2];
        exp_t x;
        pa = int'(ch_a) * int'(vol_a);
        pb = int'(ch_b) * int'(vol_b);
        pc = int'(ch_c) * int'(vol_c);
        if (stereo) begin
            l = pa + pb / 2;
            r = pc + pb / 2;
        end else begin
            l = pa + pb + pc;
            r = l;
        end
        if (tape_in) begin
            l += TAPE_LEVEL;
            r += TAPE_LEVEL;
        end
        s[0] = clamp16(l * 8 - 32768);
        s[1] = clamp16(r * 8 - 32768);
`ifdef AUDIO_MIX_DCBLOCK_EN
        for (int i = 0; i < 2; i++) begin
            int y;
            y = clamp16(s[i] - sp[i] + yp[i] - floor256(yp[i]));
            sp[i] = s[i];
            yp[i] = y;
            s[i] = y;
        end
`endif
        x.l = s[0];
        x.r = s[1];
        x.cyc = cyc;
        q.push_back(x);
    endtask

    always @(negedge clk) begin
        if (!reset && out_valid) begin
            nvld++;
            if (q.size() == 0) begin
                chk("unexpected_out_valid", 1, 0);
            end else begin
                e = q.pop_front();
                chk("left_out", int'(left_out), e.l);
                chk("right_out", int'(right_out), e.r);
                chk("latency", cyc - e.cyc, LAT);
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_in(input logic [7:0] a, b, c, input logic [3:0] va, vb, vc,
                          input logic t, st);
        ch_a = a; ch_b = b; ch_c = c;
        vol_a = va; vol_b = vb; vol_c = vc;
        tape_in = t; stereo = st;
    endtask

    task automatic issue(input bit push);
        ce = 1'b1;
        if (push) push_expected();
        tick();
        ce = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        sp = '{0, 0};
        yp = '{0, 0};
    endtask

    // Sample issued now, then the remaining cycles to just past its out_valid.
    task automatic run_sample(input string name, input int want_l);
        issue(1);
        chk({name, "_busy_c1"}, int'(busy), 1);
        tick(LAT - 1);
        chk({name, "_busy_last"}, int'(busy), 1);
        chk({name, "_valid_at_lat"}, int'(out_valid), 1);
        chk({name, "_left_const"}, int'(left_out), want_l);
        tick();
        chk({name, "_busy_done"}, int'(busy), 0);
    endtask

    initial begin
        int v0;
        ce = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        do_reset();
        chk("rst_left", int'(left_out), 0);
        chk("rst_right", int'(right_out), 0);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_overrun", int'(overrun), 0);

        // Stereo, channel A only: left mid-scale, right floor.
        set_in(8'hFF, 0, 0, 4'd15, 0, 0, 0, 1);
        run_sample("cha1", -2168);
        chk("cha1_right_const", int'(right_out), -32768);
`ifdef AUDIO_MIX_DCBLOCK_EN
        run_sample("cha2", -2159);
`else
        run_sample("cha2", -2168);
`endif

        do_reset();
        set_in(8'hFF, 8'hFF, 8'hFF, 4'd15, 4'd15, 4'd15, 1, 0);
        run_sample("mono_sat", 32767);
        chk("mono_sat_right_const", int'(right_out), 32767);

        do_reset();
        set_in(8'h5A, 8'hC3, 8'h11, 0, 0, 0, 1, 1);
        run_sample("tape_only", -24576);
        chk("tape_only_right_const", int'(right_out), -24576);

        // Second strobe while busy: dropped, overrun latched.
        do_reset();
        set_in(8'hFF, 0, 0, 4'd15, 0, 0, 0, 1);
        v0 = nvld;
        issue(1);
        tick(2);
        set_in(8'h80, 8'h80, 8'h80, 4'd7, 4'd7, 4'd7, 1, 0);
        ce = 1'b1;
        tick();
        ce = 1'b0;
        chk("overrun_set", int'(overrun), 1);
        tick(LAT + 4);
        chk("overrun_one_valid", nvld - v0, 1);
        chk("overrun_first_left", int'(left_out), -2168);
        set_in(8'h10, 8'h20, 8'h30, 4'd3, 4'd4, 4'd5, 0, 0);
        issue(1);
        tick(LAT + 2);
        chk("overrun_sticky", int'(overrun), 1);
        do_reset();
        chk("overrun_cleared", int'(overrun), 0);

        // Reset in mid-flight aborts the sample.
        set_in(8'h40, 8'h50, 8'h60, 4'd9, 4'd9, 4'd9, 0, 1);
        issue(1);
        tick(LAT + 2);
        v0 = nvld;
        issue(0);
        tick(2);
        reset = 1'b1;
        tick();
        chk("midrst_left", int'(left_out), 0);
        chk("midrst_right", int'(right_out), 0);
        chk("midrst_busy", int'(busy), 0);
        tick(2);
        reset = 1'b0;
        sp = '{0, 0};
        yp = '{0, 0};
        tick(LAT + 2);
        chk("midrst_no_valid", nvld - v0, 0);

        // Random traffic; inputs scrambled after each strobe to test the snapshot.
        for (int n = 0; n < 40; n++) begin
            set_in(8'($urandom), 8'($urandom), 8'($urandom),
                   4'($urandom), 4'($urandom), 4'($urandom),
                   1'($urandom), 1'($urandom));
            issue(1);
            set_in(8'($urandom), 8'($urandom), 8'($urandom),
                   4'($urandom), 4'($urandom), 4'($urandom),
                   1'($urandom), 1'($urandom));
            tick(8 + int'($urandom_range(0, 3)));
        end
        chk("rand_no_overrun", int'(overrun), 0);

        for (int w = 0; w < 20 && q.size() != 0; w++) tick();
        chk("scoreboard_drained", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
